// File: rtl/biu_arb_pkg.sv
// Shared encodings and state type for the BIU request arbiter.
// Latency: none, constants and types only.
// Backpressure: none, no datapath here.
package biu_arb_pkg;

    localparam logic [1:0] BURST_NORMAL = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;
    localparam logic [1:0] BURST_RSVD   = 2'b11;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // INCR and WRAP run BURST_BEATS beats; NORMAL and the reserved code are single-beat.
    function automatic logic is_multi_beat(input logic [1:0] burst);
        case (burst)
            BURST_INCR, BURST_WRAP:   return 1'b1;
            BURST_NORMAL, BURST_RSVD: return 1'b0;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/biu_req_arbiter_if.sv
// Channel-side and bus-side signal bundle for the BIU request arbiter.
// Latency: none, wires only.
// Backpressure: carried by ACK/STALL towards the bus and ch_ack/ch_stall towards channels.
interface biu_req_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]            ch_req;
    logic [NUM_CH*ADDR_W-1:0]     ch_addr;
    logic [NUM_CH*2-1:0]          ch_burst;
    logic [NUM_CH-1:0]            ch_wrb;
    logic [NUM_CH*DATA_W-1:0]     ch_wdata;
    logic [NUM_CH*(DATA_W/8)-1:0] ch_bstrobe;
    logic [NUM_CH-1:0]            ch_ack;
    logic [NUM_CH-1:0]            ch_stall;
    logic [NUM_CH-1:0]            ch_err;
    logic [DATA_W-1:0]            ch_rdata;
    logic [ADDR_W-1:0]            ADDR;
    logic [1:0]                   BURST;
    logic                         REQ;
    logic                         WRB;
    logic [DATA_W-1:0]            WDATA;
    logic [DATA_W/8-1:0]          BSTROBE;
    logic [DATA_W-1:0]            RDATA;
    logic                         ACK;
    logic                         STALL;
    logic [NUM_CH-1:0]            grant;
    logic                         busy;

    // arbiter side: masters the shared bus on behalf of the channels
    modport master (
        input  ch_req, ch_addr, ch_burst, ch_wrb, ch_wdata, ch_bstrobe, RDATA, ACK, STALL,
        output ch_ack, ch_stall, ch_err, ch_rdata, ADDR, BURST, REQ, WRB, WDATA, BSTROBE,
               grant, busy
    );

    // environment side: requesting channels plus the bus slave
    modport slave (
        output ch_req, ch_addr, ch_burst, ch_wrb, ch_wdata, ch_bstrobe, RDATA, ACK, STALL,
        input  ch_ack, ch_stall, ch_err, ch_rdata, ADDR, BURST, REQ, WRB, WDATA, BSTROBE,
               grant, busy
    );

endinterface

// File: rtl/rr_prio_picker.sv
// One-hot priority pick over a request vector, searching upward from a start index with wrap.
// Latency: combinational.
// Backpressure: none.
module rr_prio_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     winner
);

    logic [N-1:0] rot;
    logic [N-1:0] low;

    // rotate so 'start' sits at bit 0, keep the lowest set bit, rotate back
    always_comb begin
        rot = N'({req, req} >> start);
        low = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                low    = '0;
                low[i] = 1'b1;
            end
        end
        winner = N'(({low, low} << start) >> N);
    end

endmodule

// File: rtl/biu_req_arbiter.sv
// Grants one of NUM_CH requesters the BIU bus and holds ownership for a whole burst.
// Latency: 1 cycle request to bus REQ; back-to-back grants on the completing ACK edge.
// Backpressure: bus STALL/ACK pass to the owner; every other requesting channel sees stall.
module biu_req_arbiter
    import biu_arb_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BURST_BEATS = 8,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              proc_clk,
    input  logic              proc_rst,
    biu_req_arbiter_if.master bus
);

    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t        state, state_nxt;
    logic [NUM_CH-1:0] grant, grant_nxt, arb_req, pick;
    logic [IDX_W-1:0]  rr_ptr, ptr_nxt, start, pick_ptr;
    logic [3:0]        beat_cnt, beat_nxt;
    logic [15:0]       wdog, wdog_nxt;
    logic              own_req, last_beat, tmo_hit, err_now;
    logic [ADDR_W-1:0] addr_mux;
    logic [1:0]        burst_mux;
    logic              wrb_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [STRB_W-1:0] strb_mux;

    // select the owner's request fields; everything reads zero with no owner
    always_comb begin
        addr_mux  = '0;
        burst_mux = BURST_NORMAL;
        wrb_mux   = 1'b0;
        wdata_mux = '0;
        strb_mux  = '0;
        own_req   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                addr_mux  = bus.ch_addr[i*ADDR_W +: ADDR_W];
                burst_mux = bus.ch_burst[i*2 +: 2];
                wrb_mux   = bus.ch_wrb[i];
                wdata_mux = bus.ch_wdata[i*DATA_W +: DATA_W];
                strb_mux  = bus.ch_bstrobe[i*STRB_W +: STRB_W];
                own_req   = bus.ch_req[i];
            end
        end
    end

    // round-robin never hands the bus straight back to the owner that just finished
    assign arb_req   = bus.ch_req & ~((ARB_MODE == ARB_RR) ? grant : '0);
    assign start     = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr;
    assign last_beat = !is_multi_beat(burst_mux) || (beat_cnt == 4'(BURST_BEATS - 1));
    // wdog holds completed silent cycles, so the limit is hit during the last one
    assign tmo_hit   = !bus.ACK && (32'(wdog) + 32'd1 == 32'(TIMEOUT_CYC));

    rr_prio_picker #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (arb_req),
        .start  (start),
        .winner (pick)
    );

    // next search start: one past the channel being granted
    always_comb begin
        pick_ptr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick[i]) pick_ptr = (i == NUM_CH - 1) ? '0 : IDX_W'(i + 1);
        end
    end

    // ownership FSM: ACK wins over a dropped request so a final beat always completes
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = rr_ptr;
        beat_nxt  = beat_cnt;
        wdog_nxt  = wdog;
        err_now   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|bus.ch_req) begin
                    state_nxt = ST_OWN;
                    grant_nxt = pick;
                    ptr_nxt   = pick_ptr;
                    beat_nxt  = '0;
                    wdog_nxt  = '0;
                end
            end
            ST_OWN: begin
                if (bus.ACK) begin
                    wdog_nxt = '0;
                    if (!last_beat) begin
                        beat_nxt = beat_cnt + 4'd1;
                    end else if (|arb_req) begin
                        grant_nxt = pick;
                        ptr_nxt   = pick_ptr;
                        beat_nxt  = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                        grant_nxt = '0;
                        beat_nxt  = '0;
                    end
                end else if (!own_req || tmo_hit) begin
                    err_now   = 1'b1;
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    beat_nxt  = '0;
                    wdog_nxt  = '0;
                end else begin
                    wdog_nxt = wdog + 16'd1;
                end
            end
            default: ;
        endcase
    end

    // state register; reset drops ownership at once with no error pulse
    always_ff @(posedge proc_clk or posedge proc_rst) begin
        if (proc_rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            wdog     <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= ptr_nxt;
            beat_cnt <= beat_nxt;
            wdog     <= wdog_nxt;
        end
    end

    assign bus.ch_ack   = grant & {NUM_CH{bus.ACK}};
    assign bus.ch_stall = (grant & {NUM_CH{bus.STALL}}) | (~grant & bus.ch_req);
    assign bus.ch_err   = grant & {NUM_CH{err_now}};
    assign bus.ch_rdata = bus.RDATA;
    assign bus.ADDR     = addr_mux;
    assign bus.BURST    = burst_mux;
    assign bus.REQ      = own_req;
    assign bus.WRB      = wrb_mux;
    assign bus.WDATA    = wdata_mux;
    assign bus.BSTROBE  = strb_mux;
    assign bus.grant    = grant;
    assign bus.busy     = (state == ST_OWN);

endmodule

// File: tb/tb_biu_req_arbiter.sv
// Self-checking bench: directed scenarios on a fixed 2-channel and a round-robin 4-channel arbiter,
// then randomized traffic on the 4-channel one against a transaction-level model.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_biu_req_arbiter;
    import biu_arb_pkg::*;

    logic proc_clk = 1'b0;
    logic proc_rst = 1'b1;
    always #5 proc_clk = ~proc_clk;

    biu_req_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) if_f ();
    biu_req_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) if_r ();

    biu_req_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .BURST_BEATS(8),
                      .ARB_MODE(ARB_FIXED), .TIMEOUT_CYC(10))
        u_fix (.proc_clk(proc_clk), .proc_rst(proc_rst), .bus(if_f));

    biu_req_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .BURST_BEATS(8),
                      .ARB_MODE(ARB_RR), .TIMEOUT_CYC(10))
        u_rr (.proc_clk(proc_clk), .proc_rst(proc_rst), .bus(if_r));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge proc_clk);
        #1;
    endtask

    // first requester at or after 'first' (wrapping), never 'skip'; -1 when none
    function automatic int rr_pick(input logic [3:0] req, input int first, input int skip);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (first + k) % 4;
            if (req[c] && c != skip) return c;
        end
        return -1;
    endfunction

    function automatic bit multi(input logic [1:0] b);
        return (b == 2'b01) || (b == 2'b10);
    endfunction

    // reference model state: owner (-1 none), last granted, beats done, silent cycles
    int m_own, m_last, m_beats, m_wdog;
    logic [3:0]  r_req, r_wrb, e_grant, e_stall, e_ack, e_err;
    logic [1:0]  r_bur [4];
    logic [31:0] r_addr [4];
    logic [31:0] r_wd [4];
    logic [3:0]  r_st [4];
    logic        r_ack, r_stall;
    logic [31:0] r_rdata;

    initial begin
        logic [4:0]  d2_seq [5];
        logic [10:0] d3_ack, d3_stl;
        int own0, ack_pct;

        if_f.ch_req = '0; if_f.ch_addr = '0; if_f.ch_burst = '0; if_f.ch_wrb = '0;
        if_f.ch_wdata = '0; if_f.ch_bstrobe = '0; if_f.RDATA = '0; if_f.ACK = 1'b0; if_f.STALL = 1'b0;
        if_r.ch_req = '0; if_r.ch_addr = '0; if_r.ch_burst = '0; if_r.ch_wrb = '0;
        if_r.ch_wdata = '0; if_r.ch_bstrobe = '0; if_r.RDATA = '0; if_r.ACK = 1'b0; if_r.STALL = 1'b0;

        // reset values, with a request already pending
        if_r.ch_req = 4'b0001;
        repeat (2) tick();
        chk("rst_grant_r", if_r.grant, 4'b0);
        chk("rst_busy_r", if_r.busy, 1'b0);
        chk("rst_req_r", if_r.REQ, 1'b0);
        chk("rst_err_r", if_r.ch_err, 4'b0);
        chk("rst_grant_f", if_f.grant, 2'b0);
        chk("rst_busy_f", if_f.busy, 1'b0);
        if_r.ch_req = 4'b0000;
        proc_rst = 1'b0;

        // fixed priority: lowest index wins and is re-granted while it keeps asking
        if_f.ch_req = 2'b11;
        #1;
        chk("fx_idle_grant", if_f.grant, 2'b00);
        chk("fx_idle_stall", if_f.ch_stall, 2'b11);
        tick(); if_f.ACK = 1'b1; #1;
        chk("fx_t1_grant", if_f.grant, 2'b01);
        chk("fx_t1_req", if_f.REQ, 1'b1);
        chk("fx_t1_ack", if_f.ch_ack, 2'b01);
        chk("fx_t1_stall", if_f.ch_stall, 2'b10);
        tick(); #1;
        chk("fx_t2_grant", if_f.grant, 2'b01);
        chk("fx_t2_stall", if_f.ch_stall, 2'b10);
        if_f.ch_req = 2'b10; #1;
        chk("fx_t2_err", if_f.ch_err, 2'b00);
        tick(); #1;
        chk("fx_t3_grant", if_f.grant, 2'b10);
        chk("fx_t3_stall", if_f.ch_stall, 2'b00);
        if_f.ch_req = 2'b00;
        tick(); if_f.ACK = 1'b0; #1;
        chk("fx_t4_busy", if_f.busy, 1'b0);
        chk("fx_t4_grant", if_f.grant, 2'b00);

        // round-robin rotation, single beats, ACK every cycle, no bubbles
        d2_seq[0] = 5'b10001; d2_seq[1] = 5'b10010; d2_seq[2] = 5'b10100;
        d2_seq[3] = 5'b11000; d2_seq[4] = 5'b10001;
        if_r.ch_req = 4'b1111; if_r.ACK = 1'b1; #1;
        chk("rr_idle_ack", if_r.ch_ack, 4'b0);
        chk("rr_idle_stall", if_r.ch_stall, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            chk("rr_seq_grant", if_r.grant, d2_seq[k][3:0]);
            chk("rr_seq_busy", if_r.busy, d2_seq[k][4]);
        end
        if_r.ch_req = 4'b0000;
        tick(); #1;
        chk("rr_seq_done", if_r.busy, 1'b0);

        // ch1 INCR burst with a 3-cycle stall; ch0 waits, then gets the bus on the 8th ACK edge
        d3_ack = 11'b11111000111;
        d3_stl = 11'b00000111000;
        if_r.ACK = 1'b0; if_r.ch_req = 4'b0011; if_r.ch_burst = 8'b0000_0100;
        tick();
        for (int j = 0; j < 11; j++) begin
            if_r.ACK = d3_ack[j]; if_r.STALL = d3_stl[j]; #1;
            chk("burst_grant", if_r.grant, 4'b0010);
            chk("burst_ack", if_r.ch_ack, d3_ack[j] ? 4'b0010 : 4'b0000);
            chk("burst_stall", if_r.ch_stall, {2'b00, d3_stl[j], 1'b1});
            tick();
        end
        if_r.ACK = 1'b0; if_r.STALL = 1'b0; #1;
        chk("burst_handoff", if_r.grant, 4'b0001);
        chk("burst_ch1_stall", if_r.ch_stall, 4'b0010);
        if_r.ch_req = 4'b0000; if_r.ch_burst = '0; if_r.ACK = 1'b1;
        tick(); if_r.ACK = 1'b0; #1;
        chk("burst_done", if_r.busy, 1'b0);

        // watchdog: ch1 owns without ACK, error in its 10th cycle, then ch2 is granted
        if_r.ch_req = 4'b0110;
        tick();
        for (int j = 1; j <= 10; j++) begin
            #1;
            chk("tmo_grant", if_r.grant, 4'b0010);
            chk("tmo_err", if_r.ch_err, (j == 10) ? 4'b0010 : 4'b0000);
            tick();
        end
        #1;
        chk("tmo_busy", if_r.busy, 1'b0);
        chk("tmo_err_gone", if_r.ch_err, 4'b0000);
        tick(); #1;
        chk("tmo_next", if_r.grant, 4'b0100);
        if_r.ch_req = 4'b0000; if_r.ACK = 1'b1;
        tick(); if_r.ACK = 1'b0; #1;
        chk("tmo_done", if_r.busy, 1'b0);

        // ch3 WRAP burst abandoned after 3 beats: one error pulse, then idle
        if_r.ch_req = 4'b1000; if_r.ch_burst = 8'b1000_0000; if_r.ACK = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("drop_beat_err", if_r.ch_err, 4'b0000);
            chk("drop_beat_grant", if_r.grant, 4'b1000);
            tick();
        end
        if_r.ACK = 1'b0; if_r.ch_req = 4'b0000; #1;
        chk("drop_err", if_r.ch_err, 4'b1000);
        tick(); #1;
        chk("drop_busy", if_r.busy, 1'b0);
        chk("drop_err_once", if_r.ch_err, 4'b0000);
        if_r.ch_burst = '0;

        // reset mid-burst: everything drops immediately, no error pulse
        if_r.ch_req = 4'b0001; if_r.ch_burst = 8'b0000_0001; if_r.ACK = 1'b1;
        repeat (3) tick();
        if_r.ACK = 1'b0; #1;
        chk("arst_pre_req", if_r.REQ, 1'b1);
        #2 proc_rst = 1'b1; #1;
        chk("arst_req", if_r.REQ, 1'b0);
        chk("arst_grant", if_r.grant, 4'b0000);
        chk("arst_busy", if_r.busy, 1'b0);
        chk("arst_err", if_r.ch_err, 4'b0000);
        tick(); #1;
        chk("arst_err_hold", if_r.ch_err, 4'b0000);
        if_r.ch_req = 4'b0000; if_r.ch_burst = '0;
        proc_rst = 1'b0;

        // randomized traffic against the model
        m_own = -1; m_last = -1; m_beats = 0; m_wdog = 0;
        for (int c = 0; c < 4; c++) begin
            r_bur[c] = 2'b00; r_addr[c] = '0; r_wd[c] = '0; r_st[c] = '0;
        end
        r_req = '0; r_wrb = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            ack_pct = ((cyc / 250) % 4 == 3) ? 4 : 65;
            for (int c = 0; c < 4; c++) begin
                if (r_req[c]) begin
                    if ($urandom_range(0, 99) < 4) r_req[c] = 1'b0;
                end else if ($urandom_range(0, 99) < 30) begin
                    r_req[c]  = 1'b1;
                    r_bur[c]  = 2'($urandom_range(0, 3));
                    r_addr[c] = $urandom;
                end
                r_wrb[c] = 1'($urandom_range(0, 1));
                r_wd[c]  = $urandom;
                r_st[c]  = 4'($urandom_range(0, 15));
                if_r.ch_addr[32*c +: 32]  = r_addr[c];
                if_r.ch_burst[2*c +: 2]   = r_bur[c];
                if_r.ch_wdata[32*c +: 32] = r_wd[c];
                if_r.ch_bstrobe[4*c +: 4] = r_st[c];
            end
            r_ack   = ($urandom_range(0, 99) < ack_pct);
            r_stall = !r_ack && ($urandom_range(0, 1) == 1);
            r_rdata = $urandom;
            if_r.ch_req = r_req; if_r.ch_wrb = r_wrb;
            if_r.ACK = r_ack; if_r.STALL = r_stall; if_r.RDATA = r_rdata;
            #1;

            own0    = m_own;
            e_grant = (own0 >= 0) ? 4'(1 << own0) : 4'b0;
            e_ack   = r_ack ? e_grant : 4'b0;
            for (int c = 0; c < 4; c++) e_stall[c] = (c == own0) ? r_stall : r_req[c];
            e_err = 4'b0;
            if (m_own < 0) begin
                if (r_req != 4'b0) begin
                    m_own   = rr_pick(r_req, (m_last < 0) ? 0 : (m_last + 1) % 4, -1);
                    m_last  = m_own;
                    m_beats = 0;
                    m_wdog  = 0;
                end
            end else if (r_ack) begin
                m_beats++;
                m_wdog = 0;
                if (!multi(r_bur[m_own]) || m_beats == 8) begin
                    m_own   = rr_pick(r_req, (m_own + 1) % 4, m_own);
                    if (m_own >= 0) m_last = m_own;
                    m_beats = 0;
                end
            end else begin
                m_wdog++;
                if (!r_req[m_own] || m_wdog == 10) begin
                    e_err = e_grant;
                    m_own = -1; m_beats = 0; m_wdog = 0;
                end
            end

            chk("rnd_grant", if_r.grant, e_grant);
            chk("rnd_busy", if_r.busy, own0 >= 0);
            chk("rnd_req", if_r.REQ, (own0 >= 0) ? r_req[own0] : 1'b0);
            chk("rnd_wrb", if_r.WRB, (own0 >= 0) ? r_wrb[own0] : 1'b0);
            chk("rnd_ack", if_r.ch_ack, e_ack);
            chk("rnd_stall", if_r.ch_stall, e_stall);
            chk("rnd_err", if_r.ch_err, e_err);
            chk("rnd_rdata", if_r.ch_rdata, r_rdata);
            if (own0 >= 0) begin
                chk("rnd_addr", if_r.ADDR, r_addr[own0]);
                chk("rnd_burst", if_r.BURST, r_bur[own0]);
                chk("rnd_wdata", if_r.WDATA, r_wd[own0]);
                chk("rnd_strb", if_r.BSTROBE, r_st[own0]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/biu_req_arbiter.md
BIU_REQ_ARBITER -- requirements
Module: biu_req_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, 2: requester count, 2..8; channel 0 is the TLB walker by convention.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- BURST_BEATS, 8: beats per INCR/WRAP burst, power of 2, 2..16.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYC, 0: ACK watchdog limit in cycles; 0 disables it.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- proc_clk, in, 1: the only clock.
- proc_rst, in, 1: asynchronous, active-high reset.
- ch_req, in, NUM_CH: per-channel request.
- ch_addr, in, NUM_CH*ADDR_W: packed per-channel address.
- ch_burst, in, NUM_CH*2: packed burst type; 00 normal, 01 INCR, 10 WRAP, 11 reserved.
- ch_wrb, in, NUM_CH: write enable.
- ch_wdata, in, NUM_CH*DATA_W: packed write data.
- ch_bstrobe, in, NUM_CH*(DATA_W/8): packed byte strobes.
- ch_ack, out, NUM_CH: per-channel beat acknowledge.
- ch_stall, out, NUM_CH: per-channel stall.
- ch_err, out, NUM_CH: one-cycle error pulse.
- ch_rdata, out, DATA_W: read data, broadcast to all channels.
- ADDR, out, ADDR_W: bus address.
- BURST, out, 2: bus burst type.
- REQ, out, 1: bus request.
- WRB, out, 1: bus write enable.
- WDATA, out, DATA_W: bus write data.
- BSTROBE, out, DATA_W/8: bus byte strobes.
- RDATA, in, DATA_W: bus read data.
- ACK, in, 1: bus beat acknowledge.
- STALL, in, 1: bus stall.
- grant, out, NUM_CH: one-hot current owner.
- busy, out, 1: high while a transaction is in progress.

Function
REQ-003 The FSM SHALL have two states, IDLE and OWN; grant is registered and holds exactly one bit set in OWN and none in IDLE.
REQ-004 In IDLE, when any ch_req is high, the winner SHALL be chosen per ARB_MODE and the FSM SHALL enter OWN on the next edge; latency from request to bus REQ is 1 cycle.
REQ-005 In round-robin mode the search SHALL start at (last owner + 1) mod NUM_CH; after reset it starts at channel 0.
REQ-006 In OWN, ADDR, BURST, WRB, WDATA and BSTROBE SHALL be muxed combinationally from the owner, and REQ SHALL equal the owner's ch_req.
REQ-007 In IDLE, REQ and WRB SHALL be 0.
REQ-008 ch_ack[owner] SHALL equal ACK; all other ch_ack bits SHALL be 0.
REQ-009 ch_stall[owner] SHALL equal STALL; every non-owner with ch_req high SHALL see ch_stall=1.
REQ-010 A 4-bit beat counter SHALL clear on grant and increment on each ACK in OWN.
- The transaction completes on the 1st ACK for BURST 00.
- It completes on the BURST_BEATS-th ACK for 01 or 10.
- BURST 11 SHALL be treated as 00.
REQ-011 Ownership SHALL be locked until completion; no re-arbitration takes place mid-burst.
REQ-012 On the completing-ACK cycle the arbiter SHALL arbitrate among the remaining requests, excluding the completing owner in round-robin mode, and grant the winner on the same edge, giving zero bubble cycles; if no request is pending the FSM SHALL return to IDLE.
REQ-013 If the owner drops ch_req before completion, the FSM SHALL return to IDLE next edge and ch_err[owner] SHALL pulse for 1 cycle.
REQ-014 With TIMEOUT_CYC>0, a 16-bit watchdog SHALL count OWN cycles without ACK and reset on each ACK; on reaching TIMEOUT_CYC, ch_err[owner] SHALL pulse and the FSM SHALL return to IDLE.
REQ-015 ACK or STALL received in IDLE SHALL be ignored.
REQ-016 busy SHALL be high exactly when the state is OWN.

Reset
REQ-017 proc_rst SHALL asynchronously force: state IDLE, grant 0, RR pointer 0, beat counter 0, watchdog 0, ch_err 0, busy 0.
REQ-018 Reset mid-burst SHALL abandon the transaction without an error pulse; REQ falls immediately.

Structure
REQ-019 Package biu_arb_pkg SHALL hold the burst encodings (BURST_NORMAL, BURST_INCR, BURST_WRAP, BURST_RSVD), the state typedef, and the ARB_FIXED/ARB_RR constants.
REQ-020 One combinational sub-module, rr_prio_picker, SHALL take (req vector, start index) and return a one-hot winner; fixed mode uses start index 0.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- Fixed mode, NUM_CH=2, ch_req=11 in IDLE: grant=01 next cycle. After a single-beat ACK, grant=01 again while ch0 still requests, and ch1 stays stalled.
- RR mode, NUM_CH=4, all requesting single-beat reads, ACK every cycle: grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles.
- Channel 1 INCR burst with BURST_BEATS=8, STALL high for 3 cycles mid-burst, and channel 0 requesting throughout: grant stays on channel 1 until the 8th ACK, then moves to channel 0 on the same edge.
- TIMEOUT_CYC=10, owner with no ACK: ch_err[owner] pulses in the 10th OWN cycle, busy falls next cycle, and the other pending request is granted on the following arbitration.
- Owner drops ch_req after 3 of 8 beats: ch_err pulses once, then IDLE.
- proc_rst asserted mid-burst: REQ, grant and busy are 0 asynchronously, and no ch_err pulse occurs.
